// File: rtl/btn_event_ctrl.sv
// Multi-button debounce/event front end: shared tick prescaler, per-channel debounce,
// press/release/long classification and a round-robin event serialiser. Macro BTN_REPEAT_EN adds auto-repeat long events.
module btn_event_ctrl #(
   parameter int NUM_BTN      = 4,
   parameter int TICK_DIV     = 1000,
   parameter int DEB_TICKS    = 8,
   parameter int LONG_TICKS   = 200,
   parameter int REPEAT_TICKS = 50,
   parameter int IDW          = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_state,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [IDW-1:0]     evt_id,
   output logic [1:0]         evt_type,
   output logic               evt_ovf
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_TICKS + 1);
   localparam int HW = $clog2(LONG_TICKS + 1);

   logic [PW-1:0]             r_pre_cnt;
   logic                      w_tick;
   logic [NUM_BTN-1:0]        r_sync1;
   logic [NUM_BTN-1:0]        r_sync2;
   logic [NUM_BTN-1:0][2:0]   w_pend;
   logic [NUM_BTN-1:0][2:0]   w_clr;
   logic [NUM_BTN-1:0]        w_ovf_ch;

   logic                      r_evt_valid;
   logic [IDW-1:0]            r_evt_id;
   logic [1:0]                r_evt_type;
   logic                      r_evt_ovf;
   logic [IDW-1:0]            r_ptr;
   logic                      w_free;
   logic                      w_found;
   logic [IDW-1:0]            w_pick;
   logic [1:0]                w_type;
   int                        w_idx;

   assign w_tick = (r_pre_cnt == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_cnt <= '0;
         r_sync1   <= '0;
         r_sync2   <= '0;
      end else begin
         r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PW'(1);
         r_sync1   <= btn_in;
         r_sync2   <= r_sync1;
      end
   end

   // Pending flag bit order per channel: [0] press, [1] release, [2] long.
   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      logic          r_level;
      logic [DW-1:0] r_deb_cnt;
      logic [HW-1:0] r_hold_cnt;
      logic [2:0]    r_pend;
      logic          w_diff;
      logic          w_accept;
      logic          w_hold_sat;
      logic          w_long_hit;
      logic          w_long_set;
      logic [2:0]    w_set;

      assign w_diff     = (r_sync2[gi] != r_level);
      assign w_accept   = w_tick && w_diff && (r_deb_cnt == DW'(DEB_TICKS - 1));
      assign w_hold_sat = (r_hold_cnt == HW'(LONG_TICKS));
      assign w_long_hit = w_tick && r_level && !w_accept && (r_hold_cnt == HW'(LONG_TICKS - 1));

`ifdef BTN_REPEAT_EN
      localparam int RW = $clog2(REPEAT_TICKS + 1);
      logic [RW-1:0] r_rep_cnt;
      logic          w_rep_hit;

      assign w_rep_hit = w_tick && r_level && !w_accept && w_hold_sat &&
                         (r_rep_cnt == RW'(REPEAT_TICKS - 1));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_rep_cnt <= '0;
         end else if (w_tick) begin
            if (!r_level || w_accept || !w_hold_sat || w_rep_hit)
               r_rep_cnt <= '0;
            else
               r_rep_cnt <= r_rep_cnt + RW'(1);
         end
      end

      assign w_long_set = w_long_hit | w_rep_hit;
`else
      assign w_long_set = w_long_hit;
`endif

      assign w_set = {w_long_set, w_accept & ~r_sync2[gi], w_accept & r_sync2[gi]};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_level    <= 1'b0;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_pend     <= '0;
         end else begin
            if (w_tick) begin
               if (!w_diff || w_accept)
                  r_deb_cnt <= '0;
               else
                  r_deb_cnt <= r_deb_cnt + DW'(1);
               if (w_accept)
                  r_level <= r_sync2[gi];
               if (w_accept || !r_level)
                  r_hold_cnt <= '0;
               else if (!w_hold_sat)
                  r_hold_cnt <= r_hold_cnt + HW'(1);
            end
            // A set arriving with the arbiter's clear keeps the flag.
            r_pend <= (r_pend & ~w_clr[gi]) | w_set;
         end
      end

      assign w_ovf_ch[gi]  = |(w_set & r_pend & ~w_clr[gi]);
      assign w_pend[gi]    = r_pend;
      assign btn_state[gi] = r_level;
   end

   assign w_free = !r_evt_valid || evt_ready;

   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_type  = 2'b00;
      w_clr   = '0;
      w_idx   = 0;
      for (int k = 0; k < NUM_BTN; k++) begin
         w_idx = (int'(r_ptr) + k) % NUM_BTN;
         if (!w_found && (|w_pend[w_idx])) begin
            w_found = 1'b1;
            w_pick  = IDW'(w_idx);
         end
      end
      // Press before long before release keeps quick press/release pairs in order.
      if (w_free && w_found) begin
         if (w_pend[w_pick][0]) begin
            w_type         = 2'b01;
            w_clr[w_pick][0] = 1'b1;
         end else if (w_pend[w_pick][2]) begin
            w_type         = 2'b11;
            w_clr[w_pick][2] = 1'b1;
         end else begin
            w_type         = 2'b10;
            w_clr[w_pick][1] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_evt_valid <= 1'b0;
         r_evt_id    <= '0;
         r_evt_type  <= 2'b00;
         r_evt_ovf   <= 1'b0;
         r_ptr       <= '0;
      end else begin
         r_evt_ovf <= |w_ovf_ch;
         if (w_free) begin
            if (w_found) begin
               r_evt_valid <= 1'b1;
               r_evt_id    <= w_pick;
               r_evt_type  <= w_type;
               r_ptr       <= (w_pick == IDW'(NUM_BTN - 1)) ? '0 : w_pick + IDW'(1);
            end else begin
               r_evt_valid <= 1'b0;
            end
         end
      end
   end

   assign evt_valid = r_evt_valid;
   assign evt_id    = r_evt_id;
   assign evt_type  = r_evt_type;
   assign evt_ovf   = r_evt_ovf;
endmodule
